// File: rtl/booth_pkg.sv
// Shared encodings for the sequential Booth multiplier.
package booth_pkg;

  // FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Booth recoding of {Q[0], Q_1}
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into the accumulator,
// followed by an arithmetic right shift of {Aacc, Q, Q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N:0]   aacc,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N:0]   m,
  output logic [N:0]   aacc_next,
  output logic [N-1:0] q_next,
  output logic         q_1_next
);

  logic [N:0] sum;

  // Add or subtract the multiplicand according to the current bit pair
  always_comb begin
    sum = aacc;
    case ({q[0], q_1})
      ADD:     sum = aacc + m;
      SUB:     sum = aacc - m;
      default: sum = aacc;
    endcase
  end

  // Shift right by one, replicating the accumulator sign bit
  always_comb begin
    aacc_next = {sum[N], sum[N:1]};
    q_next    = {sum[0], q[N-1:1]};
    q_1_next  = q[0];
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, signed N x N -> 2N, N step cycles.
// Completion pulses done/resultWrite for one cycle; resultWrite feeds the
// write enable of the downstream result register.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           resultWrite,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  state_t        state;
  logic [CW-1:0] count;
  logic [N:0]    m;
  logic [N:0]    aacc;
  logic [N-1:0]  q;
  logic          q_1;

  logic [N:0]    aacc_next;
  logic [N-1:0]  q_next;
  logic          q_1_next;

  booth_step #(.N(N)) u_step (
    .aacc      (aacc),
    .q         (q),
    .q_1       (q_1),
    .m         (m),
    .aacc_next (aacc_next),
    .q_next    (q_next),
    .q_1_next  (q_1_next)
  );

  // Controller, datapath registers and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      m       <= '0;
      aacc    <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {a[N-1], a};
            aacc  <= '0;
            q     <= b;
            q_1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          aacc  <= aacc_next;
          q     <= q_next;
          q_1   <= q_1_next;
          count <= count + 1'b1;
          // The last step's result goes straight to the product register
          if (count == CW'(N - 1)) begin
            product <= {aacc_next[N-1:0], q_next};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign resultWrite = done;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: directed N=8 cases and a streaming
// randomized N=16 run checked against plain signed multiplication.
module tb_booth_seq_multiplier;

  localparam int LIMIT = 18200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, rw8;
  logic [15:0] product8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, rw16;
  logic [31:0] product16;

  int checks = 0;
  int errors = 0;

  logic [15:0] ha [0:LIMIT];
  logic [15:0] hb [0:LIMIT];

  always #5 clk = ~clk;

  booth_seq_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .resultWrite(rw8), .product(product8)
  );

  booth_seq_multiplier #(.N(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .resultWrite(rw16), .product(product16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[31:0];
  endfunction

  // Multiply on the N=8 instance; inj=1 re-asserts start with new operands
  // so that it is sampled at edge E0+3.
  task automatic mul8(input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp, input string tag, input bit inj);
    int pulses;
    int lat;
    pulses = 0;
    lat = -1;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    check({tag, "_busy"}, busy8, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rw"}, rw8, done8);
      if (done8) begin
        pulses++;
        if (lat < 0) lat = i;
      end
      if (inj && i == 2) begin
        a8 = 8'h55; b8 = 8'h33; start8 = 1'b1;
      end
      if (inj && i == 3) start8 = 1'b0;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_prod"}, product8, exp);
    check({tag, "_idle"}, busy8, 1'b0);
  endtask

  initial begin
    int pulses;
    int ops;
    int last;
    int c;

    #23;
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_rw", rw8, 1'b0);
    check("rst_prod8", product8, 16'h0000);
    check("rst_prod16", product16, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    mul8(8'd3,   8'd5,   16'h000F, "t1",     1'b0);
    mul8(8'hFD,  8'd5,   16'hFFF1, "t2a",    1'b0);
    mul8(8'd127, 8'h80,  16'hC080, "t2b",    1'b0);
    mul8(8'h80,  8'h80,  16'h4000, "t3a",    1'b0);
    mul8(8'd0,   8'hFF,  16'h0000, "t3b",    1'b0);
    mul8(8'd6,   8'd7,   16'h002A, "t4",     1'b0);
    mul8(8'd6,   8'd7,   16'h002A, "t4_inj", 1'b1);

    // Abort during CALC
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t5_busy_pre", busy8, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", busy8, 1'b0);
    check("t5_done", done8, 1'b0);
    check("t5_rw", rw8, 1'b0);
    check("t5_prod", product8, 16'h0000);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    check("t5_no_done", pulses, 0);
    @(negedge clk);
    reset = 1'b1;
    mul8(8'd2, 8'hF9, 16'hFFF2, "t5_after", 1'b0);

    // Streaming run: start held high, operands change every cycle
    ops = 0;
    last = 0;
    c = 0;
    @(negedge clk);
    start16 = 1'b1;
    while (ops < 1000 && c < LIMIT) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      ha[c] = a16;
      hb[c] = b16;
      @(posedge clk);
      @(negedge clk);
      if (done16) begin
        if (c < 16) begin
          check("t6_early_done", c, 16);
        end else begin
          check("t6_prod", product16, ref16(ha[c-16], hb[c-16]));
        end
        if (ops == 0) check("t6_first_lat", c, 16);
        else          check("t6_period", c - last, 18);
        last = c;
        ops++;
      end
      c++;
    end
    start16 = 1'b0;
    check("t6_ops", ops, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
